// File: rtl/cnn_load_if.sv
// Bus-side write channel between the AXI slave write path and cnn_load_controller.
// awaddr[31:16] carries the channel tag; wdata low bits carry the memory word.
interface cnn_load_if;
   logic        wvalid;
   logic        wready;
   logic [31:0] awaddr;
   logic [31:0] wdata;

   modport master (output wvalid, output awaddr, output wdata, input wready);
   modport slave  (input wvalid, input awaddr, input wdata, output wready);
endinterface

// File: rtl/cnn_load_controller.sv
// Loads tagged bus writes into NUM_CH local-memory channels with per-channel length/done tracking.
// Optional per-channel running checksum is built when LOAD_CHECKSUM_EN is defined.
module cnn_load_controller #(
   parameter int unsigned NUM_CH     = 3,
   parameter int unsigned DATA_W     = 16,
   parameter int unsigned ADDR_W     = 16,
   parameter logic [15:0] TAG_BASE   = 16'hd333,
   parameter logic [15:0] TAG_STRIDE = 16'h0111,
   parameter int unsigned MAX_LAYER  = 5
) (
   input  logic                      clk,
   input  logic                      rst,
   cnn_load_if.slave                 bus,
   input  logic                      cfg_we,
   input  logic [$clog2(NUM_CH)-1:0] cfg_ch,
   input  logic [ADDR_W-1:0]         cfg_len,
   input  logic                      next_layer,
   output logic [NUM_CH-1:0]         mem_we,
   output logic [ADDR_W-1:0]         mem_addr,
   output logic [DATA_W-1:0]         mem_wdata,
   output logic [NUM_CH-1:0]         store_done,
   output logic                      all_done,
   output logic [4:0]                layer_sel,
   output logic                      err_ovf,
   output logic [NUM_CH*16-1:0]      checksum
);

   typedef enum logic [1:0] {StIdle, StStore, StFull} ch_state_e;

   ch_state_e         state_q [NUM_CH];
   ch_state_e         state_d [NUM_CH];
   logic [ADDR_W-1:0] count_q [NUM_CH];
   logic [ADDR_W-1:0] count_d [NUM_CH];
   logic [ADDR_W-1:0] len_q   [NUM_CH];
   logic [ADDR_W-1:0] len_d   [NUM_CH];
   logic [NUM_CH-1:0] len_set_q, len_set_d;
   logic [NUM_CH-1:0] hit, full, accept;
   logic              ovf_hit;
   logic [ADDR_W-1:0] sel_addr;
   logic              unused_bits;

   function automatic logic [15:0] ch_tag(input int unsigned i);
      return TAG_BASE + 16'(i) * TAG_STRIDE;
   endfunction

   assign unused_bits = ^{bus.awaddr[15:0], bus.wdata[31:DATA_W]};

   always_comb begin
      hit      = '0;
      full     = '0;
      accept   = '0;
      ovf_hit  = 1'b0;
      sel_addr = '0;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
         hit[i]  = (bus.awaddr[31:16] == ch_tag(i));
         full[i] = (state_q[i] == StFull);
         // next_layer wins over a same-cycle write; the write is dropped without error.
         if (bus.wvalid && hit[i] && !next_layer) begin
            if (full[i]) begin
               ovf_hit = 1'b1;
            end else if (count_q[i] < len_q[i]) begin
               accept[i] = 1'b1;
            end
         end
         if (accept[i]) sel_addr = sel_addr | count_q[i];
      end
   end

   assign bus.wready = ~|(hit & full);
   assign store_done = full;
   assign all_done   = &full;

   always_comb begin
      len_set_d = len_set_q;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
         len_d[i] = len_q[i];
         if (cfg_we && (int'(cfg_ch) == int'(i))) begin
            len_d[i]     = cfg_len;
            len_set_d[i] = 1'b1;
         end
      end
   end

   // A length never programmed since reset keeps its channel idle instead of
   // reporting it as an empty (disabled) channel.
   always_comb begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
         state_d[i] = state_q[i];
         count_d[i] = count_q[i];
         if (next_layer) begin
            state_d[i] = StIdle;
            count_d[i] = '0;
         end else begin
            if (accept[i]) begin
               count_d[i] = count_q[i] + 1'b1;
               state_d[i] = (count_d[i] == len_q[i]) ? StFull : StStore;
            end
            if (state_q[i] != StFull && len_set_d[i] && count_d[i] >= len_d[i]) begin
               state_d[i] = StFull;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned i = 0; i < NUM_CH; i++) begin
            state_q[i] <= StIdle;
            count_q[i] <= '0;
            len_q[i]   <= '0;
         end
         len_set_q <= '0;
         mem_we    <= '0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         layer_sel <= '0;
         err_ovf   <= 1'b0;
      end else begin
         for (int unsigned i = 0; i < NUM_CH; i++) begin
            state_q[i] <= state_d[i];
            count_q[i] <= count_d[i];
            len_q[i]   <= len_d[i];
         end
         len_set_q <= len_set_d;
         mem_we    <= accept;
         if (|accept) begin
            mem_addr  <= sel_addr;
            mem_wdata <= bus.wdata[DATA_W-1:0];
         end
         err_ovf <= err_ovf | ovf_hit;
         if (next_layer) begin
            layer_sel <= (layer_sel == 5'(MAX_LAYER - 1)) ? 5'd0 : layer_sel + 5'd1;
         end
      end
   end

`ifdef LOAD_CHECKSUM_EN
   logic [15:0] csum_q [NUM_CH];
   logic [15:0] wd16;

   assign wd16 = 16'(bus.wdata[DATA_W-1:0]);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned i = 0; i < NUM_CH; i++) csum_q[i] <= '0;
      end else if (next_layer) begin
         for (int unsigned i = 0; i < NUM_CH; i++) csum_q[i] <= '0;
      end else begin
         for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (accept[i]) csum_q[i] <= csum_q[i] + wd16;
         end
      end
   end

   always_comb begin
      checksum = '0;
      for (int unsigned i = 0; i < NUM_CH; i++) checksum[16*i +: 16] = csum_q[i];
   end
`else
   assign checksum = '0;
`endif

endmodule

// File: tb/tb_cnn_load_controller.sv
// Self-checking bench for cnn_load_controller: vector table for the fill/overflow path,
// hand sequences for layer stepping, length reprogramming and mid-load reset.
module tb_cnn_load_controller;

   logic        clk = 1'b0;
   logic        rst;
   logic        cfg_we;
   logic [1:0]  cfg_ch;
   logic [15:0] cfg_len;
   logic        next_layer;
   logic [2:0]  mem_we;
   logic [15:0] mem_addr;
   logic [15:0] mem_wdata;
   logic [2:0]  store_done;
   logic        all_done;
   logic [4:0]  layer_sel;
   logic        err_ovf;
   logic [47:0] checksum;

   always #5 clk = ~clk;

   cnn_load_if bus ();

   cnn_load_controller dut (
      .clk        (clk),
      .rst        (rst),
      .bus        (bus),
      .cfg_we     (cfg_we),
      .cfg_ch     (cfg_ch),
      .cfg_len    (cfg_len),
      .next_layer (next_layer),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .store_done (store_done),
      .all_done   (all_done),
      .layer_sel  (layer_sel),
      .err_ovf    (err_ovf),
      .checksum   (checksum)
   );

   typedef struct {
      logic [2:0]  we;
      logic [15:0] addr;
      logic [15:0] data;
      logic [47:0] csum;
   } exp_t;

   typedef struct {
      int          ch;
      logic [15:0] data;
      bit          acc;
      bit          rdy;
      logic [2:0]  done;
      bit          err;
   } vec_t;

   exp_t        sb[$];
   exp_t        mon_e;
   vec_t        vt[10];
   logic [15:0] m_cnt[3];
   logic [15:0] m_csum[3];
   int          n_pass = 0;
   int          n_checks = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
      else n_pass++;
   endtask

   function automatic logic [31:0] ch_addr(input int ch);
      if (ch < 0) return 32'h1234_5678;
      return {16'hd333 + 16'(ch) * 16'h0111, 16'(ch * 4)};
   endfunction

   function automatic logic [47:0] csum_vec();
`ifdef LOAD_CHECKSUM_EN
      return {m_csum[2], m_csum[1], m_csum[0]};
`else
      return 48'h0;
`endif
   endfunction

   task automatic clear_model();
      for (int i = 0; i < 3; i++) begin
         m_cnt[i]  = '0;
         m_csum[i] = '0;
      end
   endtask

   // Scoreboard: every registered write must match the oldest expected write.
   always @(negedge clk) begin
      if (mem_we !== 3'b000) begin
         if (sb.size() == 0) begin
            check("spurious_mem_we", 64'(mem_we), 64'h0);
         end else begin
            mon_e = sb.pop_front();
            check("mem_we", 64'(mem_we), 64'(mon_e.we));
            check("mem_addr", 64'(mem_addr), 64'(mon_e.addr));
            check("mem_wdata", 64'(mem_wdata), 64'(mon_e.data));
            check("checksum", 64'(checksum), 64'(mon_e.csum));
         end
      end
   end

   task automatic do_write(input int ch, input logic [15:0] data, input bit acc, input bit rdy);
      exp_t e;
      bus.wvalid = 1'b1;
      bus.awaddr = ch_addr(ch);
      bus.wdata  = {16'hbeef, data};
      #2;
      check("wready", 64'(bus.wready), 64'(rdy));
      if (acc) begin
         m_csum[ch] = m_csum[ch] + data;
         e.we   = 3'(1 << ch);
         e.addr = m_cnt[ch];
         e.data = data;
         e.csum = csum_vec();
         sb.push_back(e);
         m_cnt[ch] = m_cnt[ch] + 16'd1;
      end
      @(posedge clk);
      #1;
      bus.wvalid = 1'b0;
   endtask

   task automatic do_cfg(input logic [1:0] ch, input logic [15:0] len);
      cfg_we  = 1'b1;
      cfg_ch  = ch;
      cfg_len = len;
      @(posedge clk);
      #1;
      cfg_we = 1'b0;
   endtask

   task automatic do_next();
      next_layer = 1'b1;
      @(posedge clk);
      #1;
      next_layer = 1'b0;
      clear_model();
   endtask

   initial begin
      rst        = 1'b1;
      cfg_we     = 1'b0;
      cfg_ch     = '0;
      cfg_len    = '0;
      next_layer = 1'b0;
      bus.wvalid = 1'b0;
      bus.awaddr = '0;
      bus.wdata  = '0;
      clear_model();

      vt[0] = '{0,  16'h0001, 1'b1, 1'b1, 3'b000, 1'b0};
      vt[1] = '{0,  16'h0002, 1'b1, 1'b1, 3'b000, 1'b0};
      vt[2] = '{0,  16'h0003, 1'b1, 1'b1, 3'b000, 1'b0};
      vt[3] = '{0,  16'h0004, 1'b1, 1'b1, 3'b001, 1'b0};
      vt[4] = '{-1, 16'h0009, 1'b0, 1'b1, 3'b001, 1'b0};
      vt[5] = '{1,  16'h0005, 1'b1, 1'b1, 3'b001, 1'b0};
      vt[6] = '{1,  16'h0006, 1'b1, 1'b1, 3'b011, 1'b0};
      vt[7] = '{2,  16'h0007, 1'b1, 1'b1, 3'b111, 1'b0};
      vt[8] = '{0,  16'h0008, 1'b0, 1'b0, 3'b111, 1'b1};
      vt[9] = '{1,  16'h000a, 1'b0, 1'b0, 3'b111, 1'b1};

      repeat (2) @(posedge clk);
      #1;
      check("rst_wready", 64'(bus.wready), 64'h1);
      check("rst_mem_we", 64'(mem_we), 64'h0);
      check("rst_store_done", 64'(store_done), 64'h0);
      check("rst_layer_sel", 64'(layer_sel), 64'h0);
      check("rst_err_ovf", 64'(err_ovf), 64'h0);
      check("rst_checksum", 64'(checksum), 64'h0);
      rst = 1'b0;
      @(posedge clk);
      #1;
      check("unprogrammed_done", 64'(store_done), 64'h0);

      // Fill, overflow and unmatched-tag path.
      do_cfg(2'd0, 16'd4);
      do_cfg(2'd1, 16'd2);
      do_cfg(2'd2, 16'd1);
      for (int i = 0; i < 10; i++) begin
         do_write(vt[i].ch, vt[i].data, vt[i].acc, vt[i].rdy);
         check($sformatf("v%0d_store_done", i), 64'(store_done), 64'(vt[i].done));
         check($sformatf("v%0d_err_ovf", i), 64'(err_ovf), 64'(vt[i].err));
      end
      check("all_done_full", 64'(all_done), 64'h1);

      do_next();
      check("nl_layer_sel", 64'(layer_sel), 64'h1);
      check("nl_store_done", 64'(store_done), 64'h0);
      check("nl_all_done", 64'(all_done), 64'h0);
      do_write(0, 16'h00aa, 1'b1, 1'b1);

      // Reset while a write is in flight.
      bus.wvalid = 1'b1;
      bus.awaddr = ch_addr(0);
      bus.wdata  = 32'h0000_00bb;
      @(posedge clk);
      #2;
      rst        = 1'b1;
      bus.wvalid = 1'b0;
      #1;
      clear_model();
      check("mid_rst_mem_we", 64'(mem_we), 64'h0);
      check("mid_rst_mem_addr", 64'(mem_addr), 64'h0);
      check("mid_rst_mem_wdata", 64'(mem_wdata), 64'h0);
      check("mid_rst_layer_sel", 64'(layer_sel), 64'h0);
      check("mid_rst_err_ovf", 64'(err_ovf), 64'h0);
      check("mid_rst_checksum", 64'(checksum), 64'h0);
      check("mid_rst_wready", 64'(bus.wready), 64'h1);
      @(posedge clk);
      #1;
      rst = 1'b0;

      // next_layer beats a same-cycle write.
      do_cfg(2'd0, 16'd4);
      do_cfg(2'd1, 16'd2);
      do_cfg(2'd2, 16'd1);
      bus.wvalid = 1'b1;
      bus.awaddr = ch_addr(1);
      bus.wdata  = 32'h0000_0077;
      do_next();
      bus.wvalid = 1'b0;
      check("nlw_layer_sel", 64'(layer_sel), 64'h1);
      check("nlw_err_ovf", 64'(err_ovf), 64'h0);
      do_write(1, 16'h0055, 1'b1, 1'b1);
      for (int i = 0; i < 3; i++) do_next();
      check("layer_max", 64'(layer_sel), 64'h4);
      do_next();
      check("layer_wrap", 64'(layer_sel), 64'h0);

      do_write(1, 16'hffff, 1'b1, 1'b1);
      do_write(1, 16'h0002, 1'b1, 1'b1);
`ifdef LOAD_CHECKSUM_EN
      check("csum_ch1_wrap", 64'(checksum[31:16]), 64'h0001);
`else
      check("csum_ch1_off", 64'(checksum[31:16]), 64'h0000);
`endif
      check("ch1_done", 64'(store_done), 64'h2);

      // Disabled channel and shrinking a length below the current count.
      do_cfg(2'd2, 16'd0);
      check("len0_done", 64'(store_done), 64'h6);
      do_write(0, 16'h0011, 1'b1, 1'b1);
      do_write(0, 16'h0022, 1'b1, 1'b1);
      do_write(0, 16'h0033, 1'b1, 1'b1);
      check("pre_shrink_done", 64'(store_done), 64'h6);
      do_cfg(2'd0, 16'd2);
      check("shrink_done", 64'(store_done), 64'h7);
      check("shrink_all_done", 64'(all_done), 64'h1);
      check("shrink_err_clear", 64'(err_ovf), 64'h0);
      do_write(0, 16'h0044, 1'b0, 1'b0);
      check("shrink_ovf", 64'(err_ovf), 64'h1);
      do_write(2, 16'h0066, 1'b0, 1'b0);
      check("ovf_sticky", 64'(err_ovf), 64'h1);

      repeat (3) @(posedge clk);
      #1;
      check("sb_drained", 64'(sb.size()), 64'h0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
